// File: rtl/msx_slot_master_pkg.sv
// ---------------------------------------------------------------------------
// msx_slot_pkg
// Shared definitions for the MSX slot bus initiator.
//   state_t        : bus-cycle FSM states (IDLE, T1, T2, TW, T3)
//   CLK_PER_T_DEF  : default clk ticks per Z80 T-state (21.47727 MHz / 6)
//   STROBE_OFS_DEF : default tick inside a T-state where strobes change
//   tick_w()       : width of the tick counter for a given CLK_PER_T
// ---------------------------------------------------------------------------
package msx_slot_pkg;

  localparam int unsigned CLK_PER_T_DEF  = 6;
  localparam int unsigned STROBE_OFS_DEF = 3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    TW   = 3'd3,
    T3   = 3'd4
  } state_t;

  // Counter must hold 0..n-1; never narrower than one bit.
  function automatic int unsigned tick_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/msx_slot_master_if.sv
// ---------------------------------------------------------------------------
// msx_slot_master_if
// Groups the host request handshake and the cartridge slot bus.
//   Host side : req, ready, we, address, wdata, rdata, done (+ m1)
//   Slot side : slot_a, slot_d_out, slot_d_oe, slot_d_in, slot_nsltsl,
//               slot_nmerq, slot_nrd, slot_nwr, slot_nwait
// Modports:
//   master : the initiator (msx_slot_master)
//   slave  : the host plus cartridge that surround it
// Optional macro MSX_SLOT_MASTER_M1_WAIT_EN adds the m1 request qualifier.
//
// Handshake: a request is accepted on a rising clk edge where req and ready
// are both 1. we/address/wdata (and m1) are captured on that edge only.
// ready stays 0 until the bus cycle has finished; req seen while ready is 0
// is ignored, not queued. done pulses for one clk when the cycle ends, and
// rdata is valid from done until the next read completes.
// ---------------------------------------------------------------------------
interface msx_slot_master_if;

  logic        req;
  logic        ready;
  logic        we;
  logic [15:0] address;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        done;
`ifdef MSX_SLOT_MASTER_M1_WAIT_EN
  logic        m1;
`endif

  logic [15:0] slot_a;
  logic [7:0]  slot_d_out;
  logic        slot_d_oe;
  logic [7:0]  slot_d_in;
  logic        slot_nsltsl;
  logic        slot_nmerq;
  logic        slot_nrd;
  logic        slot_nwr;
  logic        slot_nwait;

  modport master (
    input  req, we, address, wdata, slot_d_in, slot_nwait,
`ifdef MSX_SLOT_MASTER_M1_WAIT_EN
    input  m1,
`endif
    output ready, rdata, done, slot_a, slot_d_out, slot_d_oe,
           slot_nsltsl, slot_nmerq, slot_nrd, slot_nwr
  );

  modport slave (
    output req, we, address, wdata, slot_d_in, slot_nwait,
`ifdef MSX_SLOT_MASTER_M1_WAIT_EN
    output m1,
`endif
    input  ready, rdata, done, slot_a, slot_d_out, slot_d_oe,
           slot_nsltsl, slot_nmerq, slot_nrd, slot_nwr
  );

endinterface

// File: rtl/msx_slot_master_tstate_timer.sv
// ---------------------------------------------------------------------------
// msx_tstate_timer
// Tick counter k = 0..CLK_PER_T-1 inside one T-state.
//   clk, reset        : system clock, synchronous active-high reset
//   restart_i         : force k to 0 (request accepted)
//   run_i             : advance k, wrapping after CLK_PER_T-1
//   first_tick_o      : k == 0
//   strobe_tick_o     : k == STROBE_OFS-1
//   pre_last_tick_o   : k == CLK_PER_T-2
//   last_tick_o       : k == CLK_PER_T-1
// The "pre" ticks exist because every slot output is a register: to have a
// strobe visible during tick STROBE_OFS it must be loaded on the edge that
// ends tick STROBE_OFS-1. Requires 1 <= STROBE_OFS < CLK_PER_T, CLK_PER_T >= 3.
// ---------------------------------------------------------------------------
module msx_tstate_timer
  import msx_slot_pkg::*;
#(
  parameter int unsigned CLK_PER_T  = CLK_PER_T_DEF,
  parameter int unsigned STROBE_OFS = STROBE_OFS_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic restart_i,
  input  logic run_i,
  output logic first_tick_o,
  output logic strobe_tick_o,
  output logic pre_last_tick_o,
  output logic last_tick_o
);

  localparam int unsigned   KW           = tick_w(CLK_PER_T);
  localparam logic [KW-1:0] K_LAST       = KW'(CLK_PER_T - 1);
  localparam logic [KW-1:0] K_PRE_LAST   = KW'(CLK_PER_T - 2);
  localparam logic [KW-1:0] K_PRE_STROBE = KW'(STROBE_OFS - 1);

  logic [KW-1:0] k_q, k_d;

  always_comb begin
    k_d = k_q;
    if (restart_i) begin
      k_d = '0;
    end else if (run_i) begin
      k_d = (k_q == K_LAST) ? '0 : k_q + KW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      k_q <= '0;
    end else begin
      k_q <= k_d;
    end
  end

  assign first_tick_o    = (k_q == '0);
  assign strobe_tick_o   = (k_q == K_PRE_STROBE);
  assign pre_last_tick_o = (k_q == K_PRE_LAST);
  assign last_tick_o     = (k_q == K_LAST);

endmodule

// File: rtl/msx_slot_master.sv
// ---------------------------------------------------------------------------
// msx_slot_master
// Z80-side MSX slot initiator: turns one accepted host request into one
// MSX memory read or write cycle (T1, T2, optional TW..., T3), each state
// CLK_PER_T clk long, with cartridge /WAIT support.
//   clk, reset : 21.47727 MHz system clock, synchronous active-high reset
//   bus        : msx_slot_master_if.master (host handshake + slot bus)
//   state_o    : current FSM state, for observation
// Optional macro MSX_SLOT_MASTER_M1_WAIT_EN: adds bus.m1; a read accepted
// with m1=1 gets one unconditional TW after T2 before /WAIT is honoured.
// A reset that interrupts a bus cycle leaves the previous rdata readable;
// a reset from IDLE (including power-up) clears it.
// ---------------------------------------------------------------------------
module msx_slot_master
  import msx_slot_pkg::*;
#(
  parameter int unsigned CLK_PER_T  = CLK_PER_T_DEF,
  parameter int unsigned STROBE_OFS = STROBE_OFS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  msx_slot_master_if.master bus,
  output state_t            state_o
);

  state_t      state_q;
  logic        ready_q, done_q;
  logic [7:0]  rdata_q;
  logic [15:0] slot_a_q;
  logic [7:0]  d_out_q;
  logic        d_oe_q;
  logic        nsltsl_q, nmerq_q, nrd_q, nwr_q;
  logic        we_q;
  logic [7:0]  wdata_q;
  logic        m1_read;

  logic first_tick, strobe_tick, pre_last_tick, last_tick;
  logic accept;

  assign accept = (state_q == IDLE) && bus.req;

`ifdef MSX_SLOT_MASTER_M1_WAIT_EN
  logic m1_q;
  // m1 only matters for reads (opcode fetch); writes ignore it.
  assign m1_read = m1_q && !we_q;
`else
  assign m1_read = 1'b0;
`endif

  msx_tstate_timer #(
    .CLK_PER_T  (CLK_PER_T),
    .STROBE_OFS (STROBE_OFS)
  ) u_timer (
    .clk             (clk),
    .reset           (reset),
    .restart_i       (accept),
    .run_i           (state_q != IDLE),
    .first_tick_o    (first_tick),
    .strobe_tick_o   (strobe_tick),
    .pre_last_tick_o (pre_last_tick),
    .last_tick_o     (last_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      slot_a_q <= '0;
      d_out_q  <= '0;
      d_oe_q   <= 1'b0;
      nsltsl_q <= 1'b1;
      nmerq_q  <= 1'b1;
      nrd_q    <= 1'b1;
      nwr_q    <= 1'b1;
      we_q     <= 1'b0;
      wdata_q  <= '0;
`ifdef MSX_SLOT_MASTER_M1_WAIT_EN
      m1_q     <= 1'b0;
`endif
      if (state_q inside {T1, T2, TW, T3}) begin
        rdata_q <= rdata_q;
      end else begin
        rdata_q <= '0;
      end
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.req) begin
            we_q     <= bus.we;
            wdata_q  <= bus.wdata;
            slot_a_q <= bus.address;
`ifdef MSX_SLOT_MASTER_M1_WAIT_EN
            m1_q     <= bus.m1;
`endif
            ready_q  <= 1'b0;
            state_q  <= T1;
          end
        end
        T1: begin
          if (strobe_tick) begin
            nmerq_q  <= 1'b0;
            nsltsl_q <= 1'b0;
            if (we_q) begin
              d_oe_q  <= 1'b1;
              d_out_q <= wdata_q;
            end else begin
              nrd_q <= 1'b0;
            end
          end
          if (last_tick) state_q <= T2;
        end
        T2: begin
          if (strobe_tick && we_q) nwr_q <= 1'b0;
          if (last_tick) state_q <= (m1_read || !bus.slot_nwait) ? TW : T3;
        end
        TW: begin
          if (last_tick && bus.slot_nwait) state_q <= T3;
        end
        T3: begin
          if (first_tick && !we_q) rdata_q <= bus.slot_d_in;
          if (strobe_tick) begin
            nrd_q    <= 1'b1;
            nwr_q    <= 1'b1;
            nmerq_q  <= 1'b1;
            nsltsl_q <= 1'b1;
          end
          if (pre_last_tick) begin
            done_q <= 1'b1;
            d_oe_q <= 1'b0;
          end
          if (last_tick) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ready       = ready_q;
  assign bus.done        = done_q;
  assign bus.rdata       = rdata_q;
  assign bus.slot_a      = slot_a_q;
  assign bus.slot_d_out  = d_out_q;
  assign bus.slot_d_oe   = d_oe_q;
  assign bus.slot_nsltsl = nsltsl_q;
  assign bus.slot_nmerq  = nmerq_q;
  assign bus.slot_nrd    = nrd_q;
  assign bus.slot_nwr    = nwr_q;
  assign state_o         = state_q;

endmodule
